// File: rtl/snake_dir_queue.sv
// snake_dir_queue
//   Direction register for the snake game with a small turn queue.
//   Raw direction buttons are synchronised (2 flops), debounced and
//   edge-detected. One press per cycle is considered, by priority
//   left > right > up > down. A press is accepted only if it is a
//   90-degree turn relative to the reference direction: the queue tail,
//   or the current direction when the queue is empty. Accepted turns are
//   queued and applied one per step pulse.
//
//   Optional build macro SNAKE_DIR_PAUSE_EN adds a debounced pause button
//   (port pause) that toggles a paused state (port paused_o). While
//   paused, steps and direction presses are ignored and the queue is kept.
//
// Ports:
//   clk       system clock
//   reset     asynchronous, active-high reset
//   left/right/up/down  raw async buttons, active-high
//   step      one-clock game tick; applies the next queued turn
//   flush     synchronous queue clear (direction unchanged)
//   clr_ovf   clears the overflow flag
//   out       current direction: 000 right, 001 left, 010 up, 011 down
//   q_count   number of queued turns
//   overflow  sticky: an accepted turn was dropped on a full queue
module snake_dir_queue #(
  parameter int QDEPTH    = 4,
  parameter int DB_CYCLES = 65536,
  parameter int CNT_W     = $clog2(QDEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             up,
  input  logic             down,
  input  logic             step,
  input  logic             flush,
  input  logic             clr_ovf,
`ifdef SNAKE_DIR_PAUSE_EN
  input  logic             pause,
  output logic             paused_o,
`endif
  output logic [2:0]       out,
  output logic [CNT_W-1:0] q_count,
  output logic             overflow
);

  localparam int AW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int DBW = $clog2(DB_CYCLES + 1);
`ifdef SNAKE_DIR_PAUSE_EN
  localparam int NB  = 5;
`else
  localparam int NB  = 4;
`endif

  localparam logic [DBW-1:0]   DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  // Button index equals the direction code; index 4 is pause when built in.
  logic [NB-1:0] raw;
`ifdef SNAKE_DIR_PAUSE_EN
  assign raw = {pause, down, up, left, right};
`else
  assign raw = {down, up, left, right};
`endif

  // Opposite directions differ only in bit 0, so a turn is legal exactly
  // when the vertical/horizontal axis bit changes.
  function automatic logic legal_turn(input logic [1:0] dir, input logic [1:0] ref_dir);
    return dir[1] != ref_dir[1];
  endfunction

  logic [NB-1:0]  sync_p0, sync_p1, db_p2, db_prev_p3;
  logic [DBW-1:0] db_cnt [NB];
  logic [NB-1:0]  press;

  // Stage p0/p1: two-flop synchroniser; p2: debounced level; p3: edge history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0    <= '0;
      sync_p1    <= '0;
      db_p2      <= '0;
      db_prev_p3 <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync_p0    <= raw;
      sync_p1    <= sync_p0;
      db_prev_p3 <= db_p2;
      for (int i = 0; i < NB; i++) begin
        if (sync_p1[i] != db_p2[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_p2[i]  <= sync_p1[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DBW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = db_p2 & ~db_prev_p3;

  logic       press_vld;
  logic [1:0] press_dir;

  always_comb begin
    press_vld = 1'b0;
    press_dir = 2'b00;
    if (press[1])      begin press_vld = 1'b1; press_dir = 2'b01; end
    else if (press[0]) begin press_vld = 1'b1; press_dir = 2'b00; end
    else if (press[2]) begin press_vld = 1'b1; press_dir = 2'b10; end
    else if (press[3]) begin press_vld = 1'b1; press_dir = 2'b11; end
  end

  logic paused;
`ifdef SNAKE_DIR_PAUSE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         paused <= 1'b0;
    else if (press[4]) paused <= ~paused;
  end
  assign paused_o = paused;
`else
  assign paused = 1'b0;
`endif

  logic [1:0]       mem [QDEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       dir;
  logic [1:0]       ref_dir;
  logic             full, pop, push_req, push, ovf_set;

  // A one-entry queue being popped still uses its entry as reference:
  // that entry becomes the direction on the same edge.
  assign ref_dir  = (count == '0) ? dir : mem[wr_ptr - AW'(1)];
  assign full     = (count == FULL_CNT);
  assign pop      = step && (count != '0) && !flush && !paused;
  assign push_req = press_vld && legal_turn(press_dir, ref_dir) && !flush && !paused;
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  // Stage p4: queue storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= press_dir;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dir      <= 2'b00;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
          dir    <= mem[rd_ptr];
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign out     = {1'b0, dir};
  assign q_count = count;

endmodule

// File: tb/tb_snake_dir_queue.sv
// Directed bench for snake_dir_queue with QDEPTH=4, DB_CYCLES=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_snake_dir_queue;

  localparam int QDEPTH = 4;
  localparam int DB     = 4;
  localparam int CNT_W  = $clog2(QDEPTH + 1);

  logic clk = 1'b0;
  logic reset, left, right, up, down, step, flush, clr_ovf;
  logic [2:0]       out;
  logic [CNT_W-1:0] q_count;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snake_dir_queue #(.QDEPTH(QDEPTH), .DB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .up(up),
    .down(down), .step(step), .flush(flush), .clr_ovf(clr_ovf),
    .out(out), .q_count(q_count), .overflow(overflow)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // code: 0 right, 1 left, 2 up, 3 down; bitmask allows simultaneous presses
  task automatic set_btn(input logic [3:0] m);
    right = m[0]; left = m[1]; up = m[2]; down = m[3];
  endtask

  task automatic press(input logic [3:0] m);
    set_btn(m);
    tick(10);
    set_btn(4'b0000);
    tick(10);
  endtask

  task automatic pulse_step();
    step = 1'b1; tick(1); step = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(2); reset = 1'b0; tick(1);
  endtask

  logic [2:0] exp_out [4];

  initial begin
    reset = 1'b1; left = 0; right = 0; up = 0; down = 0;
    step = 0; flush = 0; clr_ovf = 0;
    tick(2);
    check("reset_out", 8'(out), 8'h0);
    check("reset_qcount", 8'(q_count), 8'h0);
    check("reset_ovf", 8'(overflow), 8'h0);
    reset = 1'b0; tick(1);

    // Reversal and repeat of 'right' are both rejected
    press(4'b0010);
    press(4'b0001);
    check("reject_qcount", 8'(q_count), 8'h0);
    check("reject_out", 8'(out), 8'h0);

    // Single turn up, applied by step
    press(4'b0100);
    check("up_queued", 8'(q_count), 8'h1);
    pulse_step();
    check("up_qcount_after_step", 8'(q_count), 8'h0);
    check("up_out", 8'(out), 8'h2);

    // Three queued turns applied on successive steps
    do_reset();
    press(4'b0100);
    press(4'b0010);
    press(4'b1000);
    check("three_queued", 8'(q_count), 8'h3);
    pulse_step(); check("seq_out0", 8'(out), 8'h2);
    pulse_step(); check("seq_out1", 8'(out), 8'h1);
    pulse_step(); check("seq_out2", 8'(out), 8'h3);
    check("seq_empty", 8'(q_count), 8'h0);

    // Fill queue, then overflow, then clear flag
    do_reset();
    press(4'b0100);
    press(4'b0010);
    press(4'b0100);
    press(4'b0010);
    check("full_qcount", 8'(q_count), 8'h4);
    press(4'b1000);
    check("ovf_set", 8'(overflow), 8'h1);
    check("ovf_qcount", 8'(q_count), 8'h4);
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    check("ovf_cleared", 8'(overflow), 8'h0);

    // Push on full queue coinciding with step: push lands on edge 3+DB
    set_btn(4'b1000);
    tick(2 + DB);
    step = 1'b1; tick(1); step = 1'b0;
    tick(3);
    set_btn(4'b0000);
    tick(10);
    check("fullstep_out", 8'(out), 8'h2);
    check("fullstep_qcount", 8'(q_count), 8'h4);
    check("fullstep_ovf", 8'(overflow), 8'h0);
    exp_out[0] = 3'd1; exp_out[1] = 3'd2; exp_out[2] = 3'd1; exp_out[3] = 3'd3;
    for (int i = 0; i < 4; i++) begin
      pulse_step();
      check($sformatf("drain_out%0d", i), 8'(out), 8'(exp_out[i]));
    end
    check("drain_empty", 8'(q_count), 8'h0);

    // Bring direction to up, then coincident left+up: only left considered
    press(4'b0010); pulse_step();
    press(4'b0100); pulse_step();
    check("pre_prio_out", 8'(out), 8'h2);
    press(4'b0110);
    check("prio_qcount", 8'(q_count), 8'h1);
    pulse_step();
    check("prio_out", 8'(out), 8'h1);

    // Short glitch on down produces no event
    set_btn(4'b1000); tick(2); set_btn(4'b0000); tick(15);
    check("glitch_qcount", 8'(q_count), 8'h0);

    // Flush with coincident step
    press(4'b0100);
    press(4'b0010);
    check("flush_pre_qcount", 8'(q_count), 8'h2);
    flush = 1'b1; step = 1'b1; tick(1); flush = 1'b0; step = 1'b0;
    check("flush_qcount", 8'(q_count), 8'h0);
    check("flush_out", 8'(out), 8'h1);

    // Reset while a press is mid-debounce
    set_btn(4'b0100);
    tick(3);
    reset = 1'b1; set_btn(4'b0000);
    #1;
    check("async_reset_out", 8'(out), 8'h0);
    tick(1);
    reset = 1'b0;
    tick(15);
    check("post_reset_qcount", 8'(q_count), 8'h0);
    check("post_reset_out", 8'(out), 8'h0);
    check("post_reset_ovf", 8'(overflow), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
